// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: widths, PC-1/PC-2 index tables (1-based DES
// bit numbers), per-round shift schedules and the scheduler state type.
package des_pkg;

    localparam int DES_KEY_W    = 64;
    localparam int DES_CD_W     = 56;
    localparam int DES_SUBKEY_W = 48;

    localparam int unsigned PC1_TBL [0:DES_CD_W-1] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [0:DES_SUBKEY_W-1] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Decryption walks the encryption schedule backwards; entry 0 is zero because
    // the full 28-bit rotation brings C16/D16 back to C0/D0.
    localparam int unsigned SHIFT_DEC [0:15] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int unsigned SHIFT_ENC [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_EMIT = 2'd2
    } sched_state_t;

    function automatic logic [0:27] rot_r28(input logic [0:27] v, input int unsigned n);
        case (n)
            1:       return {v[27], v[0:26]};
            2:       return {v[26:27], v[0:25]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/des_pc1_block.sv
// PC-1 permutation: 64-bit key (bit 0 = DES bit 1) to 56-bit C||D; parity bits dropped.
module des_pc1_block
    import des_pkg::*;
(
    input  logic [0:DES_KEY_W-1] key,
    output logic [0:DES_CD_W-1]  cd
);

    for (genvar i = 0; i < DES_CD_W; i++) begin : g_bit
        assign cd[i] = key[PC1_TBL[i] - 1];
    end

endmodule

// File: rtl/des_pc2_block.sv
// PC-2 permutation: 56-bit C||D to a 48-bit round subkey (bit 0 = DES bit 1).
module des_pc2_block
    import des_pkg::*;
(
    input  logic [0:DES_CD_W-1]     cd,
    output logic [0:DES_SUBKEY_W-1] subkey
);

    for (genvar i = 0; i < DES_SUBKEY_W; i++) begin : g_bit
        assign subkey[i] = cd[PC2_TBL[i] - 1];
    end

endmodule

// File: rtl/des_dec_key_sched.sv
// Reverse-order DES subkey streamer (K16 down to K1) with valid/ready on both sides.
// Optional per-byte odd-parity check on accepted keys: DES_KEY_PARITY_CHECK_EN.
module des_dec_key_sched
    import des_pkg::*;
#(
    parameter bit REG_OUT = 1'b0
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:DES_KEY_W-1]    key_in,
    input  logic                    key_valid,
    output logic                    key_ready,
    output logic [0:DES_SUBKEY_W-1] subkey,
    output logic [3:0]              round_idx,
    output logic                    subkey_valid,
    input  logic                    subkey_ready,
    output logic                    sched_done,
    output logic                    key_parity_err
);

    // Handshake: a transfer happens on a rising edge where valid && ready; a
    // producer holds valid and data stable until that edge, ready may toggle freely.

    sched_state_t state_q, state_nxt;
    logic [0:27]  c_q, d_q, c_nxt, d_nxt;
    logic [3:0]   cnt_q, cnt_nxt;
    logic [3:0]   shift_idx;
    logic         live_q;
    logic         key_hs, sub_hs, load_out;
    logic [0:DES_CD_W-1]     pc1_cd;
    logic [0:DES_SUBKEY_W-1] pc2_key;

    des_pc1_block u_pc1 (.key(key_in), .cd(pc1_cd));
    des_pc2_block u_pc2 (.cd({c_q, d_q}), .subkey(pc2_key));

    assign key_ready    = live_q && (state_q == ST_IDLE);
    assign subkey_valid = (state_q == ST_EMIT);
    assign key_hs       = key_valid && key_ready;
    assign sub_hs       = subkey_valid && subkey_ready;
    assign sched_done   = sub_hs && (cnt_q == 4'd15);

    // With the output register, C/D run one round ahead of the registered subkey.
    assign shift_idx = (REG_OUT && state_q == ST_EMIT) ? cnt_q + 4'd2 : cnt_q + 4'd1;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        c_nxt     = c_q;
        d_nxt     = d_q;
        load_out  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_hs) begin
                    c_nxt     = pc1_cd[0:27];
                    d_nxt     = pc1_cd[28:55];
                    cnt_nxt   = 4'd0;
                    state_nxt = REG_OUT ? ST_PREP : ST_EMIT;
                end
            end
            ST_PREP: begin
                load_out  = 1'b1;
                c_nxt     = rot_r28(c_q, SHIFT_DEC[shift_idx]);
                d_nxt     = rot_r28(d_q, SHIFT_DEC[shift_idx]);
                state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                if (sub_hs) begin
                    if (cnt_q == 4'd15) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        load_out = 1'b1;
                        cnt_nxt  = cnt_q + 4'd1;
                        c_nxt    = rot_r28(c_q, SHIFT_DEC[shift_idx]);
                        d_nxt    = rot_r28(d_q, SHIFT_DEC[shift_idx]);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            c_q     <= '0;
            d_q     <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            c_q     <= c_nxt;
            d_q     <= d_nxt;
            live_q  <= 1'b1;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [0:DES_SUBKEY_W-1] subkey_q;
        logic [3:0]              idx_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                subkey_q <= '0;
                idx_q    <= 4'd0;
            end else if (load_out) begin
                subkey_q <= pc2_key;
                idx_q    <= 4'd0 - cnt_nxt;
            end
        end

        assign subkey    = subkey_q;
        assign round_idx = idx_q;
    end else begin : g_comb_out
        assign subkey    = pc2_key;
        assign round_idx = 4'd0 - cnt_q;
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic par_bad, par_err_q;

    always_comb begin
        par_bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            par_bad = par_bad | ~(^key_in[8*k +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (key_hs) begin
            par_err_q <= par_bad;
        end
    end

    assign key_parity_err = par_err_q;
`else
    assign key_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: vector table of keys against a forward-schedule
// reference model, plus hand sequences for reset, back-to-back keys and REG_OUT.
module tb_des_dec_key_sched;

    localparam logic [63:0] STD_KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY2     = 64'h0E329232EA6D0D73;
    localparam logic [63:0] BAD_PAR  = 64'h123457799BBCDFF1;
    localparam logic [47:0] STD_K16  = 48'hCB3D8B0E17F5;
    localparam logic [47:0] STD_K1   = 48'h1B02EFFC7072;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int LSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [0:63] key_in;
    logic        key_valid, key_ready, subkey_valid, subkey_ready, sched_done, key_parity_err;
    logic [0:47] subkey;
    logic [3:0]  round_idx;

    logic        key_valid_r, key_ready_r, subkey_valid_r, subkey_ready_r, sched_done_r, key_parity_err_r;
    logic [0:47] subkey_r;
    logic [3:0]  round_idx_r;

    des_dec_key_sched #(.REG_OUT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .subkey(subkey), .round_idx(round_idx), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .sched_done(sched_done), .key_parity_err(key_parity_err));

    des_dec_key_sched #(.REG_OUT(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid_r), .key_ready(key_ready_r),
        .subkey(subkey_r), .round_idx(round_idx_r), .subkey_valid(subkey_valid_r),
        .subkey_ready(subkey_ready_r), .sched_done(sched_done_r), .key_parity_err(key_parity_err_r));

    // scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] exp_q[$];
    logic [3:0]  exp_idx_q[$];
    logic [47:0] ref_ks [16];

    typedef struct {
        logic [63:0] key;
        int          stall_pct;
        logic [47:0] exp_first;
        logic [47:0] exp_last;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Forward schedule with cumulative left rotations; ref_ks[r-1] holds K_r.
    task automatic build_ref(input logic [63:0] k);
        bit cd0 [56];
        bit cd  [56];
        int tot = 0;
        for (int i = 0; i < 56; i++) cd0[i] = k[64 - PC1_T[i]];
        for (int r = 0; r < 16; r++) begin
            tot += LSHIFT[r];
            for (int j = 0; j < 28; j++) begin
                cd[j]      = cd0[(j + tot) % 28];
                cd[28 + j] = cd0[28 + (j + tot) % 28];
            end
            for (int j = 0; j < 48; j++) ref_ks[r][47 - j] = cd[PC2_T[j] - 1];
        end
    endtask

    function automatic logic exp_parity(input logic [63:0] k);
        logic bad = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
        for (int b = 0; b < 8; b++) bad = bad | ~(^k[8*b +: 8]);
`endif
        return bad;
    endfunction

    task automatic push_stream(input logic [63:0] k);
        build_ref(k);
        for (int r = 16; r >= 1; r--) begin
            exp_q.push_back(ref_ks[r - 1]);
            exp_idx_q.push_back(4'(r));
        end
    endtask

    task automatic wait_key_ready(input logic use_r);
        int cyc = 0;
        while (((use_r ? key_ready_r : key_ready) !== 1'b1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("key_ready_wait", {63'd0, use_r ? key_ready_r : key_ready}, 64'd1);
    endtask

    // Offers k at a negedge, returns on the negedge after the accepting edge.
    task automatic send_key(input logic [63:0] k);
        wait_key_ready(1'b0);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        #1;
        check("first_valid_latency", {63'd0, subkey_valid}, 64'd1);
        check("parity_flag", {63'd0, key_parity_err}, {63'd0, exp_parity(k)});
    endtask

    task automatic drain(input int n, input int stall_pct, output int cyc,
                         output logic [47:0] first_sk, output logic [47:0] last_sk);
        int          got = 0;
        bit          prev_stall = 0, prev_done = 0, drop_valid = 0;
        logic [47:0] prev_sk = '0, e_sk;
        logic [3:0]  e_idx;
        cyc = 0;
        first_sk = '0;
        last_sk = '0;
        while (got < n && cyc < 400) begin
            if (drop_valid) begin
                key_valid  = 1'b0;
                drop_valid = 0;
            end
            subkey_ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (prev_stall) check("stall_stable", subkey, prev_sk);
            if (prev_done) check("key_ready_after_done", {63'd0, key_ready}, 64'd1);
            if (key_valid && key_ready) begin
                check("key_accept_timing", {63'd0, prev_done}, 64'd1);
                drop_valid = 1;
            end
            if (subkey_valid && subkey_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_subkey", subkey, 64'hdead);
                end else begin
                    e_sk  = exp_q.pop_front();
                    e_idx = exp_idx_q.pop_front();
                    check("subkey", subkey, e_sk);
                    check("round_idx", round_idx, e_idx);
                    check("sched_done", {63'd0, sched_done}, {63'd0, e_idx == 4'd1});
                end
                got++;
                if (got == 1) first_sk = subkey;
                last_sk = subkey;
            end else begin
                check("no_done_idle", {63'd0, sched_done}, 64'd0);
            end
            prev_stall = subkey_valid && !subkey_ready;
            prev_sk    = subkey;
            prev_done  = sched_done;
            cyc++;
            @(negedge clk);
        end
        if (drop_valid) key_valid = 1'b0;
        if (got < n) check("drain_timeout", 64'(got), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [47:0] f_sk, l_sk;

        key_in = '0;
        key_valid = 1'b0;
        subkey_ready = 1'b0;
        key_valid_r = 1'b0;
        subkey_ready_r = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_key_ready", {63'd0, key_ready}, 64'd0);
        check("rst_subkey_valid", {63'd0, subkey_valid}, 64'd0);
        check("rst_subkey", subkey, 64'd0);
        check("rst_round_idx", round_idx, 64'd0);
        check("rst_sched_done", {63'd0, sched_done}, 64'd0);
        check("rst_parity", {63'd0, key_parity_err}, 64'd0);
        check("rst_subkey_r", subkey_r, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("key_ready_after_rst", {63'd0, key_ready}, 64'd1);
        @(negedge clk);

        // vector table: known-answer key first, then model-checked keys
        vecs[0] = '{STD_KEY, 0, STD_K16, STD_K1};
        vecs[1] = '{STD_KEY, 50, STD_K16, STD_K1};
        vecs[2] = '{KEY2, 30, 48'd0, 48'd0};
        vecs[3] = '{BAD_PAR, 20, 48'd0, 48'd0};
        for (int i = 4; i < 7; i++) vecs[i] = '{{$urandom, $urandom}, $urandom_range(60), 48'd0, 48'd0};
        for (int i = 2; i < 7; i++) begin
            build_ref(vecs[i].key);
            vecs[i].exp_first = ref_ks[15];
            vecs[i].exp_last  = ref_ks[0];
        end

        for (int i = 0; i < 7; i++) begin
            push_stream(vecs[i].key);
            send_key(vecs[i].key);
            drain(16, vecs[i].stall_pct, cyc, f_sk, l_sk);
            check("stream_first", f_sk, vecs[i].exp_first);
            check("stream_last", l_sk, vecs[i].exp_last);
            if (vecs[i].stall_pct == 0) check("back_to_back_cycles", 64'(cyc), 64'd16);
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            #1;
            check("parity_hold", {63'd0, key_parity_err}, {63'd0, exp_parity(vecs[i].key)});
            @(negedge clk);
        end

        // reset after the 5th handshake, then restart cleanly
        push_stream(STD_KEY);
        send_key(STD_KEY);
        drain(5, 0, cyc, f_sk, l_sk);
        rst_n = 1'b0;
        #1;
        check("midrst_subkey_valid", {63'd0, subkey_valid}, 64'd0);
        check("midrst_key_ready", {63'd0, key_ready}, 64'd0);
        exp_q.delete();
        exp_idx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_key_ready_release", {63'd0, key_ready}, 64'd1);
        @(negedge clk);
        push_stream(STD_KEY);
        send_key(STD_KEY);
        drain(16, 10, cyc, f_sk, l_sk);
        check("restart_first", f_sk, STD_K16);

        // key_valid held across a whole stream with a second key waiting
        push_stream(STD_KEY);
        push_stream(KEY2);
        wait_key_ready(1'b0);
        key_in    = STD_KEY;
        key_valid = 1'b1;
        @(negedge clk);
        key_in = KEY2;
        drain(32, 0, cyc, f_sk, l_sk);
        check("held_valid_last", l_sk, vecs[2].exp_last);
        check("held_valid_queue_empty", 64'(exp_q.size()), 64'd0);
        key_valid = 1'b0;
        @(negedge clk);

        // REG_OUT instance: first valid two cycles after the key handshake
        build_ref(STD_KEY);
        wait_key_ready(1'b1);
        key_in         = STD_KEY;
        key_valid_r    = 1'b1;
        subkey_ready_r = 1'b1;
        @(negedge clk);
        key_valid_r = 1'b0;
        #1;
        check("regout_t1_valid", {63'd0, subkey_valid_r}, 64'd0);
        @(negedge clk);
        #1;
        check("regout_t2_valid", {63'd0, subkey_valid_r}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                subkey_ready_r = 1'b0;
                @(negedge clk);
                #1;
                check("regout_stall_subkey", subkey_r, ref_ks[15 - i]);
                check("regout_stall_done", {63'd0, sched_done_r}, 64'd0);
                subkey_ready_r = 1'b1;
                #1;
            end
            check("regout_valid", {63'd0, subkey_valid_r}, 64'd1);
            check("regout_subkey", subkey_r, ref_ks[15 - i]);
            check("regout_round_idx", round_idx_r, 64'((16 - i) % 16));
            check("regout_sched_done", {63'd0, sched_done_r}, {63'd0, i == 15});
            @(negedge clk);
            #1;
        end
        check("regout_idle_after", {63'd0, subkey_valid_r}, 64'd0);
        subkey_ready_r = 1'b0;

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_dec_key_sched.md
Name: des_dec_key_sched

Overview:
Reverse-order DES round-key generator for the decryption datapath. It accepts a 64-bit key, applies PC-1 internally, and streams the 16 48-bit subkeys in decryption order (K16 first, K1 last). Subkeys are produced by right-rotating C/D and applying PC-2. It uses a valid/ready handshake on both sides and sits between key storage and the Feistel round engine.

Parameters:
REG_OUT, 0, 1 adds an output register stage on subkey/round_idx. This gives +1 cycle first-key latency; the handshake semantics are unchanged.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_in  in  [0:63]  DES key, bit 0 = DES bit 1 (MSB-first numbering)
key_valid  in  1  key_in is valid
key_ready  out  1  block can accept a key
subkey  out  [0:47]  current round subkey, bit 0 = DES bit 1
round_idx  out  4  DES round number of subkey, 16 down to 1 (encoded 4'd0 represents 16)
subkey_valid  out  1  subkey/round_idx are valid
subkey_ready  in  1  consumer accepts subkey
sched_done  out  1  one-cycle pulse when K1 is accepted
key_parity_err  out  1  odd-parity violation on last accepted key (see Optional Feature)

Behaviour:
- Reset values:
  - key_ready=0 during reset, and 1 in the first cycle after reset release.
  - subkey_valid=0, subkey=0, round_idx=0, sched_done=0, key_parity_err=0.
  - C/D registers=0, FSM=IDLE.
- Reset is asynchronous at any time, including mid-stream. All state clears and no partial stream resumes.
- FSM states:
  - IDLE: key_ready=1. On key_valid&key_ready: C/D <= PC-1(key_in), cnt <= 0, go to EMIT.
  - EMIT: subkey_valid=1 and subkey=PC-2(C,D).
    - On subkey_valid&subkey_ready with cnt<15: C and D each rotate right by SHIFT_DEC[cnt+1], cnt++, stay in EMIT.
    - With cnt==15: go to IDLE and pulse sched_done.
  - key_ready=0 in EMIT. A new key is accepted only in IDLE, so a key is never accepted in the same cycle as the final subkey handshake.
- SHIFT_DEC = {0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}. The first subkey uses unrotated C0D0, since C0D0 = C16D16 (total rotation 28).
- round_idx = 16-cnt (mod-16 encoding, 0 represents 16).
- Latency: key handshake at cycle t gives subkey_valid=1 at t+1 (t+2 with REG_OUT=1).
- Back-to-back: with subkey_ready held high, 16 subkeys are emitted on 16 consecutive cycles. key_ready rises the cycle after sched_done.
- Stall: while subkey_valid=1 and subkey_ready=0, subkey and round_idx stay stable and C/D hold.
- Inputs are ignored while key_ready=0. key_valid has no effect outside IDLE.

Optional Feature:
Macro: DES_KEY_PARITY_CHECK_EN.
- Defined: on key acceptance, check that each byte key_in[8k:8k+7] has odd parity (these bits include the 8 bits dropped by PC-1).
  - key_parity_err is registered at acceptance and holds until the next key is accepted.
  - Subkey generation proceeds regardless of the flag.
- Undefined: the port still exists and is tied to 0; no parity logic is synthesised.

Decomposition:
- des_pkg holds:
  - DES_KEY_W=64, DES_CD_W=56, DES_SUBKEY_W=48.
  - PC-1 and PC-2 index tables.
  - SHIFT_DEC and SHIFT_ENC schedule arrays.
  - FSM state typedef.
- Sub-module des_pc2_block: combinational 56->48 PC-2 permutation, instantiated once on {C,D}.
- PC-1 reuses the existing PC-1 permutation block, instantiated on key_in.

Test Plan:
1. Key 133457799BBCDFF1, subkey_ready=1 -> first subkey CB3D8B0E17F5 with round_idx=0 (16), last subkey 1B02EFFC7072 with round_idx=1; 16 consecutive valid cycles; sched_done on the 16th handshake.
2. Same key, subkey_ready toggled randomly -> identical 16-value sequence; subkey stable during every stall cycle.
3. Assert rst_n=0 after the 5th subkey handshake -> subkey_valid=0 immediately; after release, key_ready=1; reload of 133457799BBCDFF1 restarts at CB3D8B0E17F5.
4. key_valid held high across a whole stream with a second key 0E329232EA6D0D73 -> second key accepted only the cycle after sched_done; its stream follows without mixing.
5. With DES_KEY_PARITY_CHECK_EN defined: key 133457799BBCDFF1 -> key_parity_err=0; key 123457799BBCDFF1 -> key_parity_err=1 and 16 subkeys still emitted.
6. REG_OUT=1 with key 133457799BBCDFF1 -> first subkey_valid at t+2; sequence identical to scenario 1.
